// File: rtl/ee354_project_tick_sched.sv
// Purpose: game-step scheduler; divides Clk into ticks, queues direction presses, sequences move/check/apple.
// Latency: tick -> Move_Req in 2 cycles (WAIT->POP->MOVE); requests drop the cycle after their Done.
// Backpressure: Move_Req/Apple_Req hold until Done; a tick arriving mid-sequence is held (one deep) and flags Overrun.
// Optional feature: define TICK_SPEEDUP_EN to shorten the tick period as the snake grows.
module ee354_project_tick_sched #(
    parameter int TICK_CYCLES     = 25_000_000,
    parameter int MIN_TICK_CYCLES = 5_000_000,
    parameter int SPEED_STEP      = 500_000,
    parameter int TICK_W          = 27
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Dir_Valid,
    input  logic [1:0]  In_Dirn,
    input  logic [7:0]  Length,
    output logic        Move_Req,
    output logic [1:0]  Move_Dirn,
    input  logic        Move_Done,
    input  logic        Collision,
    input  logic        Ate,
    output logic        Apple_Req,
    input  logic        Apple_Done,
    output logic        Game_Over,
    output logic        Overrun,
    output logic [15:0] Step_Count,
    output logic        Busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        POP   = 3'd2,
        MOVE  = 3'd3,
        CHECK = 3'd4,
        APPLE = 3'd5,
        HALT  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   cnt_q, cnt_d;
    logic [TICK_W-1:0]   period_q, period_d;
    logic [TICK_W-1:0]   period_new;
    logic                tick_pend_q, tick_pend_d;
    logic                overrun_q, overrun_d;
    logic [1:0]          cur_dir_q, cur_dir_d;
    logic [1:0]          q0_q, q0_d;
    logic [1:0]          q1_q, q1_d;
    logic [1:0]          qcnt_q, qcnt_d;
    logic                coll_q, coll_d;
    logic                ate_q, ate_d;
    logic [15:0]         step_q, step_d;
    logic                cnt_run;
    logic                tick;
    logic [1:0]          ref_dir;
    logic                push_ok;

`ifdef TICK_SPEEDUP_EN
    localparam int PW = TICK_W + 8;
    logic [7:0]    len_eff;
    logic [PW-1:0] reduce;

    // Period shrinks by SPEED_STEP per length unit above 3, floored at MIN_TICK_CYCLES.
    always_comb begin
        len_eff    = (Length < 8'd3) ? 8'd3 : Length;
        reduce     = PW'(len_eff - 8'd3) * PW'(SPEED_STEP);
        period_new = TICK_W'(TICK_CYCLES);
        if ((reduce + PW'(MIN_TICK_CYCLES)) >= PW'(TICK_CYCLES)) begin
            period_new = TICK_W'(MIN_TICK_CYCLES);
        end else begin
            period_new = TICK_W'(PW'(TICK_CYCLES) - reduce);
        end
    end
`else
    logic unused_length;
    assign unused_length = ^Length;
    assign period_new    = TICK_W'(TICK_CYCLES);
`endif

    assign cnt_run = (state_q != IDLE) && (state_q != HALT);
    assign tick    = cnt_run && (cnt_q == (period_q - TICK_W'(1)));

    // Tick counter: parked at 0 in IDLE, frozen in HALT, period re-latched at each wrap and on IDLE exit.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (Run) begin
                period_d = period_new;
            end
        end else if (cnt_run) begin
            if (tick) begin
                cnt_d    = '0;
                period_d = period_new;
            end else begin
                cnt_d = cnt_q + TICK_W'(1);
            end
        end
    end

    // Direction queue: pop in POP, then compare a press against the post-pop tail (or current direction).
    always_comb begin
        cur_dir_d = cur_dir_q;
        q0_d      = q0_q;
        q1_d      = q1_q;
        qcnt_d    = qcnt_q;
        ref_dir   = cur_dir_q;
        push_ok   = 1'b0;
        if (state_q == IDLE) begin
            cur_dir_d = 2'b11;
            qcnt_d    = 2'd0;
        end else begin
            if ((state_q == POP) && (qcnt_q != 2'd0)) begin
                cur_dir_d = q0_q;
                q0_d      = q1_q;
                qcnt_d    = qcnt_q - 2'd1;
            end
            // With two entries the queue is full, so the tail only matters at depth one.
            ref_dir = (qcnt_d == 2'd0) ? cur_dir_d : q0_d;
            push_ok = Dir_Valid && (state_q != HALT) && (qcnt_d != 2'd2)
                      && (In_Dirn != ref_dir)
                      && !((In_Dirn[1] == ref_dir[1]) && (In_Dirn[0] != ref_dir[0]));
            if (push_ok) begin
                if (qcnt_d == 2'd0) begin
                    q0_d = In_Dirn;
                end else begin
                    q1_d = In_Dirn;
                end
                qcnt_d = qcnt_d + 2'd1;
            end
        end
    end

    // Step sequencer: next state, handshake latching, tick pending/overrun bookkeeping.
    always_comb begin
        state_d     = state_q;
        tick_pend_d = tick_pend_q;
        overrun_d   = overrun_q;
        coll_d      = coll_q;
        ate_d       = ate_q;
        step_d      = step_q;
        if (tick && (state_q != WAIT)) begin
            tick_pend_d = 1'b1;
            overrun_d   = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                tick_pend_d = 1'b0;
                if (Run) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!Run) begin
                    state_d = IDLE;
                end else if (tick || tick_pend_q) begin
                    state_d     = POP;
                    tick_pend_d = 1'b0;
                end
            end
            POP: begin
                state_d = MOVE;
            end
            MOVE: begin
                if (Move_Done) begin
                    coll_d  = Collision;
                    ate_d   = Ate;
                    step_d  = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (coll_q) begin
                    state_d = HALT;
                end else if (ate_q) begin
                    state_d = APPLE;
                end else begin
                    state_d = Run ? WAIT : IDLE;
                end
            end
            APPLE: begin
                if (Apple_Done) begin
                    state_d = Run ? WAIT : IDLE;
                end
            end
            HALT: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops all requests immediately.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= TICK_W'(TICK_CYCLES);
            tick_pend_q <= 1'b0;
            overrun_q   <= 1'b0;
            cur_dir_q   <= 2'b11;
            q0_q        <= 2'b00;
            q1_q        <= 2'b00;
            qcnt_q      <= 2'd0;
            coll_q      <= 1'b0;
            ate_q       <= 1'b0;
            step_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            tick_pend_q <= tick_pend_d;
            overrun_q   <= overrun_d;
            cur_dir_q   <= cur_dir_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            qcnt_q      <= qcnt_d;
            coll_q      <= coll_d;
            ate_q       <= ate_d;
            step_q      <= step_d;
        end
    end

    assign Move_Req   = (state_q == MOVE);
    assign Apple_Req  = (state_q == APPLE);
    assign Game_Over  = (state_q == CHECK) && coll_q;
    assign Move_Dirn  = cur_dir_q;
    assign Overrun    = overrun_q;
    assign Step_Count = step_q;
    assign Busy       = (state_q != IDLE) && (state_q != WAIT);

endmodule

// File: tb/tb_ee354_project_tick_sched.sv
module tb_ee354_project_tick_sched;

`ifdef TICK_SPEEDUP_EN
    localparam int P7  = 12;
    localparam int P20 = 8;
`else
    localparam int P7  = 20;
    localparam int P20 = 20;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Run = 1'b0;
    logic        Dir_Valid = 1'b0;
    logic [1:0]  In_Dirn = 2'b00;
    logic [7:0]  Length = 8'd7;
    logic        Move_Req;
    logic [1:0]  Move_Dirn;
    logic        Move_Done = 1'b0;
    logic        Collision = 1'b0;
    logic        Ate = 1'b0;
    logic        Apple_Req;
    logic        Apple_Done = 1'b0;
    logic        Game_Over;
    logic        Overrun;
    logic [15:0] Step_Count;
    logic        Busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    ee354_project_tick_sched #(
        .TICK_CYCLES(20),
        .MIN_TICK_CYCLES(8),
        .SPEED_STEP(2),
        .TICK_W(8)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Run(Run),
        .Dir_Valid(Dir_Valid),
        .In_Dirn(In_Dirn),
        .Length(Length),
        .Move_Req(Move_Req),
        .Move_Dirn(Move_Dirn),
        .Move_Done(Move_Done),
        .Collision(Collision),
        .Ate(Ate),
        .Apple_Req(Apple_Req),
        .Apple_Done(Apple_Done),
        .Game_Over(Game_Over),
        .Overrun(Overrun),
        .Step_Count(Step_Count),
        .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance until Move_Req is seen; n = cycles taken.
    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!Move_Req && n < 200) begin
            tick();
            n++;
        end
        check(tag, Move_Req, 1'b1);
    endtask

    // Return Move_Done one cycle after the request is seen; ends observing CHECK.
    task automatic do_move(input logic coll, input logic ate);
        tick();
        Move_Done = 1'b1;
        Collision = coll;
        Ate       = ate;
        tick();
        Move_Done = 1'b0;
        Collision = 1'b0;
        Ate       = 1'b0;
    endtask

    task automatic press(input logic [1:0] d);
        Dir_Valid = 1'b1;
        In_Dirn   = d;
        tick();
        Dir_Valid = 1'b0;
    endtask

    initial begin
        int n;
        int t_a;
        int t_b;

        // Reset values while Reset is held low
        tick();
        tick();
        check("rst_move_req", Move_Req, 1'b0);
        check("rst_apple_req", Apple_Req, 1'b0);
        check("rst_game_over", Game_Over, 1'b0);
        check("rst_overrun", Overrun, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_step", Step_Count, 16'd0);
        check("rst_dirn", Move_Dirn, 2'b11);
        Reset = 1'b1;
        tick();

        // First tick: WAIT entry to Move_Req is P+1 cycles; a left press against right is dropped
        Run = 1'b1;
        tick();
        press(2'b10);
        wait_req("req1_seen", n);
        check("first_latency", n + 1, P7 + 1);
        t_a = cyc;
        check("move1_dirn", Move_Dirn, 2'b11);
        do_move(1'b0, 1'b0);
        check("move1_step", Step_Count, 16'd1);
        check("move1_req_drop", Move_Req, 1'b0);

        // Up queued, down dropped as a reversal of the queued up
        tick();
        press(2'b00);
        press(2'b01);
        wait_req("req2_seen", n);
        t_b = cyc;
        check("tick_spacing", t_b - t_a, P7);
        check("move2_dirn", Move_Dirn, 2'b00);
        do_move(1'b0, 1'b0);
        check("move2_step", Step_Count, 16'd2);

        // Done strobes ignored while no request is up
        tick();
        Move_Done  = 1'b1;
        Apple_Done = 1'b1;
        tick();
        Move_Done  = 1'b0;
        Apple_Done = 1'b0;
        check("done_ignored_step", Step_Count, 16'd2);
        check("done_ignored_busy", Busy, 1'b0);

        // Apple sequence
        wait_req("req3_seen", n);
        do_move(1'b0, 1'b1);
        check("check_apple_req", Apple_Req, 1'b0);
        check("check_busy", Busy, 1'b1);
        tick();
        check("apple_req_high", Apple_Req, 1'b1);
        tick();
        check("apple_req_hold", Apple_Req, 1'b1);
        Apple_Done = 1'b1;
        tick();
        Apple_Done = 1'b0;
        check("apple_req_drop", Apple_Req, 1'b0);
        check("apple_back_wait", Busy, 1'b0);
        check("move3_step", Step_Count, 16'd3);

        // Overrun: hold Move_Done off past a full tick period
        wait_req("req4_seen", n);
        check("overrun_before", Overrun, 1'b0);
        repeat (25) tick();
        check("overrun_set", Overrun, 1'b1);
        check("overrun_req_hold", Move_Req, 1'b1);
        Move_Done = 1'b1;
        tick();
        Move_Done = 1'b0;
        check("move4_step", Step_Count, 16'd4);
        wait_req("req5_seen", n);
        check("pending_tick_latency", n, 3);

        // Collision: single Game_Over pulse, HALT until Run drops
        do_move(1'b1, 1'b0);
        check("game_over_pulse", Game_Over, 1'b1);
        check("move5_step", Step_Count, 16'd5);
        tick();
        check("game_over_clear", Game_Over, 1'b0);
        check("halt_busy", Busy, 1'b1);
        repeat (30) tick();
        check("halt_no_req", Move_Req, 1'b0);
        check("halt_still_busy", Busy, 1'b1);
        check("halt_dirn", Move_Dirn, 2'b00);
        Run = 1'b0;
        tick();
        tick();
        check("idle_busy", Busy, 1'b0);
        check("idle_dirn", Move_Dirn, 2'b11);
        check("overrun_sticky", Overrun, 1'b1);

        // Queue full: up and left queued, down dropped
        Run = 1'b1;
        tick();
        press(2'b00);
        press(2'b10);
        press(2'b01);
        wait_req("q_req1_seen", n);
        check("q_move1_dirn", Move_Dirn, 2'b00);
        do_move(1'b0, 1'b0);
        wait_req("q_req2_seen", n);
        check("q_move2_dirn", Move_Dirn, 2'b10);
        do_move(1'b0, 1'b0);
        wait_req("q_req3_seen", n);
        check("q_move3_dirn", Move_Dirn, 2'b10);
        do_move(1'b0, 1'b0);
        check("q_step", Step_Count, 16'd8);

        // Length change takes effect from the next wrap
        Length = 8'd20;
        wait_req("len_req1_seen", n);
        t_a = cyc;
        do_move(1'b0, 1'b0);
        wait_req("len_req2_seen", n);
        t_b = cyc;
        check("len20_spacing", t_b - t_a, P20);
        do_move(1'b0, 1'b0);

        // Asynchronous reset mid-request
        wait_req("rst_req_seen", n);
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_req", Move_Req, 1'b0);
        check("async_rst_step", Step_Count, 16'd0);
        Reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
